// File: rtl/custom_axi_ip_pkg.sv
// Shared types and constants for the custom AXI IP command issuer.
// Downstream status encodings and issuer FSM states live here.
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        STAT_IDLE  = 2'd0,
        STAT_BUSY  = 2'd1,
        STAT_DONE  = 2'd2,
        STAT_ERROR = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_IDLE = 2'd2
    } issuer_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 8;
    localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/custom_axi_ip_cmd_fifo.sv
// Command FIFO: power-of-two depth, registered occupancy count.
// Push while full is accepted only when a pop frees the slot.
module custom_axi_ip_cmd_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic                     pop_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_q, wr_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/custom_axi_ip_cmd_issuer.sv
// Issues queued commands one at a time to a downstream stage,
// tracking its IDLE/BUSY/DONE/ERROR handshake with a timeout.
module custom_axi_ip_cmd_issuer
    import custom_axi_ip_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     s_valid_i,
    input  logic [DATA_WIDTH-1:0]    s_data_i,
    output logic                     s_ready_o,
    input  logic [1:0]               status_i,
    output logic [DATA_WIDTH-1:0]    din_o,
    output logic                     enable_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         issued_cnt_o,
    output logic                     error_o,
    input  logic                     clear_err_i
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    status_e               status;
    issuer_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] din_q, din_d, head;
    logic                  en_q, en_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  push, full, empty;
    logic                  issue, set_err, done, timed_out;

    assign status    = status_e'(status_i);
    assign s_ready_o = !full;
    assign push      = s_valid_i && s_ready_o;
    assign timed_out = (tcnt_q == TW'(TIMEOUT - 1));

    custom_axi_ip_cmd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (s_data_i),
        .pop_i   (issue),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && status == STAT_IDLE) state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (status == STAT_BUSY || status == STAT_DONE) begin
                    state_d = ST_WAIT_IDLE;
                end else if (status == STAT_ERROR) begin
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (status == STAT_IDLE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue   = 1'b0;
        set_err = 1'b0;
        done    = 1'b0;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                issue = !empty && status == STAT_IDLE;
                if (issue) tcnt_d = '0;
            end
            ST_WAIT_BUSY: begin
                if (status == STAT_ERROR) begin
                    set_err = 1'b1;
                end else if (status == STAT_IDLE) begin
                    // A silent downstream drops the command after TIMEOUT cycles.
                    if (timed_out) set_err = 1'b1;
                    else           tcnt_d  = tcnt_q + TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                done    = (status == STAT_IDLE);
                set_err = (status == STAT_ERROR);
            end
            default: begin
                issue = 1'b0;
            end
        endcase
    end

    assign din_d = issue ? head : din_q;
    assign en_d  = issue;
    assign cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;
    assign err_d = set_err ? 1'b1 : (clear_err_i ? 1'b0 : err_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            din_q  <= '0;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            tcnt_q <= '0;
        end else begin
            din_q  <= din_d;
            en_q   <= en_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign din_o        = din_q;
    assign enable_o     = en_q;
    assign issued_cnt_o = cnt_q;
    assign error_o      = err_q;

endmodule
